// File: rtl/air_zone_ctrl.sv
// air_zone_ctrl: per-zone IDLE/HEAT/COOL hysteresis controllers sharing one
// setpoint and band, with zone enables, global mode, minimum dwell and a busy-zone count.
module air_zone_ctrl #(
  parameter int WIDTH = 5,
  parameter int ZONES = 4,
  parameter int DWELL = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 mode,
  input  logic [ZONES-1:0]           zone_en,
  input  logic [WIDTH-1:0]           setpoint,
  input  logic [WIDTH-1:0]           band,
  input  logic [ZONES*WIDTH-1:0]     temperature,
  output logic [ZONES-1:0]           heating,
  output logic [ZONES-1:0]           cooling,
  output logic [$clog2(ZONES+1)-1:0] active_cnt
);
  localparam int CW = $clog2(ZONES+1);
  // DWELL=0 keeps a 1-bit counter that only ever loads 0, so it stays constant 0.
  localparam int DW = (DWELL > 0) ? $clog2(DWELL+1) : 1;
  localparam logic [WIDTH:0]  T_MAX    = {1'b0, {WIDTH{1'b1}}};
  localparam logic [DW-1:0]   DWELL_LD = DW'(DWELL);
  localparam logic [DW-1:0]   DW_ONE   = DW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAT = 2'b10,
    COOL = 2'b01
  } state_t;

  state_t          state_r [ZONES];
  state_t          state_s [ZONES];
  logic [DW-1:0]   dwell_r [ZONES];
  logic [DW-1:0]   dwell_s [ZONES];
  logic [CW-1:0]   active_cnt_r;
  logic [WIDTH:0]  sp_s;
  logic [WIDTH:0]  b_s;
  logic [WIDTH:0]  heat_thr_s;
  logic [WIDTH:0]  cool_thr_s;
  logic            cool_ok_s;
  logic [ZONES-1:0] heat_on_s;
  logic [ZONES-1:0] heat_off_s;
  logic [ZONES-1:0] cool_on_s;
  logic [ZONES-1:0] cool_off_s;
  logic [ZONES-1:0] busy_s;

  function automatic logic [CW-1:0] popcount(input logic [ZONES-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < ZONES; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Shared thresholds; heat threshold saturates at 0, cool threshold may exceed range.
  always_comb begin
    sp_s       = {1'b0, setpoint};
    b_s        = (band == {WIDTH{1'b0}}) ? {{WIDTH{1'b0}}, 1'b1} : {1'b0, band};
    heat_thr_s = (b_s > sp_s) ? {(WIDTH+1){1'b0}} : (sp_s - b_s);
    cool_thr_s = sp_s + b_s;
    cool_ok_s  = (cool_thr_s <= T_MAX);
  end

  // Per-zone threshold comparisons in WIDTH+1 bits.
  always_comb begin
    heat_on_s  = '0;
    heat_off_s = '0;
    cool_on_s  = '0;
    cool_off_s = '0;
    for (int z = 0; z < ZONES; z++) begin
      heat_on_s[z]  = ({1'b0, temperature[z*WIDTH +: WIDTH]} <= heat_thr_s);
      heat_off_s[z] = ({1'b0, temperature[z*WIDTH +: WIDTH]} >= sp_s);
      cool_on_s[z]  = cool_ok_s && ({1'b0, temperature[z*WIDTH +: WIDTH]} >= cool_thr_s);
      cool_off_s[z] = ({1'b0, temperature[z*WIDTH +: WIDTH]} <= sp_s);
    end
  end

  // Next-state and dwell logic; forced IDLE overrides the dwell hold.
  always_comb begin
    busy_s = '0;
    for (int z = 0; z < ZONES; z++) begin
      state_s[z] = state_r[z];
      dwell_s[z] = dwell_r[z];
      if (!zone_en[z] || (mode == 2'b00) ||
          ((state_r[z] == HEAT) && (mode == 2'b10)) ||
          ((state_r[z] == COOL) && (mode == 2'b01))) begin
        state_s[z] = IDLE;
        dwell_s[z] = '0;
      end else if (dwell_r[z] != '0) begin
        dwell_s[z] = dwell_r[z] - DW_ONE;
      end else begin
        case (state_r[z])
          IDLE: begin
            if (heat_on_s[z] && mode[0]) begin
              state_s[z] = HEAT;
              dwell_s[z] = DWELL_LD;
            end else if (cool_on_s[z] && mode[1]) begin
              state_s[z] = COOL;
              dwell_s[z] = DWELL_LD;
            end else begin
              state_s[z] = IDLE;
            end
          end
          HEAT: begin
            if (heat_off_s[z]) begin
              state_s[z] = IDLE;
              dwell_s[z] = DWELL_LD;
            end else begin
              state_s[z] = HEAT;
            end
          end
          COOL: begin
            if (cool_off_s[z]) begin
              state_s[z] = IDLE;
              dwell_s[z] = DWELL_LD;
            end else begin
              state_s[z] = COOL;
            end
          end
          default: begin
            state_s[z] = IDLE;
            dwell_s[z] = '0;
          end
        endcase
      end
      busy_s[z] = (state_s[z] != IDLE);
    end
  end

  // State, dwell and active-count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < ZONES; z++) begin
        state_r[z] <= IDLE;
        dwell_r[z] <= '0;
      end
      active_cnt_r <= '0;
    end else begin
      for (int z = 0; z < ZONES; z++) begin
        state_r[z] <= state_s[z];
        dwell_r[z] <= dwell_s[z];
      end
      active_cnt_r <= popcount(busy_s);
    end
  end

  // Output decode straight from the state registers.
  always_comb begin
    heating = '0;
    cooling = '0;
    for (int z = 0; z < ZONES; z++) begin
      heating[z] = (state_r[z] == HEAT);
      cooling[z] = (state_r[z] == COOL);
    end
  end

  assign active_cnt = active_cnt_r;

endmodule

// File: tb/tb_air_zone_ctrl.sv
// Scoreboard bench for air_zone_ctrl: a DWELL=0 and a DWELL=3 instance share stimulus.
module tb_air_zone_ctrl;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mode;
  logic [3:0]  zone_en;
  logic [4:0]  setpoint;
  logic [4:0]  band;
  logic [19:0] temperature;
  logic [3:0]  heat0, cool0, heat3, cool3;
  logic [2:0]  cnt0, cnt3;

  typedef struct packed {
    logic [3:0] heat;
    logic [3:0] cool;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  air_zone_ctrl #(.WIDTH(5), .ZONES(4), .DWELL(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .zone_en(zone_en),
    .setpoint(setpoint), .band(band), .temperature(temperature),
    .heating(heat0), .cooling(cool0), .active_cnt(cnt0)
  );

  air_zone_ctrl #(.WIDTH(5), .ZONES(4), .DWELL(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .zone_en(zone_en),
    .setpoint(setpoint), .band(band), .temperature(temperature),
    .heating(heat3), .cooling(cool3), .active_cnt(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_temps(input logic [4:0] t0, t1, t2, t3);
    temperature = {t3, t2, t1, t0};
  endtask

  // Return both instances to a quiet, dwell-free IDLE under default settings.
  task automatic settle();
    setpoint = 5'd20;
    band     = 5'd2;
    mode     = 2'b11;
    zone_en  = 4'b1111;
    set_temps(5'd20, 5'd20, 5'd20, 5'd20);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    settle();
    checks++;
    if ({heat0, cool0, cnt0} !== 11'd0) begin
      errors++;
      $display("FAIL reset dut0: got h=%b c=%b n=%0d expected all 0", heat0, cool0, cnt0);
    end
    checks++;
    if ({heat3, cool3, cnt3} !== 11'd0) begin
      errors++;
      $display("FAIL reset dut3: got h=%b c=%b n=%0d expected all 0", heat3, cool3, cnt3);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    logic [4:0] temps [7] = '{5'd20, 5'd19, 5'd21, 5'd16, 5'd20, 5'd24, 5'd20};
    logic [1:0] hc    [7] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    exp_t       e;
    logic [2:0] en;
    settle();
    for (int i = 0; i < 7; i++) begin
      set_temps(temps[i], 5'd20, 5'd20, 5'd20);
      sbq.push_back('{heat: {3'b000, hc[i][1]}, cool: {3'b000, hc[i][0]}});
      @(posedge clk);
      @(negedge clk);
      e  = sbq.pop_front();
      en = 3'($countones(e.heat | e.cool));
      checks++;
      if ({heat0, cool0, cnt0} !== {e.heat, e.cool, en}) begin
        errors++;
        $display("FAIL sequence step %0d: got h=%b c=%b n=%0d expected h=%b c=%b n=%0d",
                 i, heat0, cool0, cnt0, e.heat, e.cool, en);
      end
    end
  endtask

  task automatic test_dwell();
    logic [4:0] first [2] = '{5'd16, 5'd24};
    logic       on    [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_t       e;
    logic [2:0] en;
    for (int p = 0; p < 2; p++) begin
      settle();
      for (int i = 0; i < 7; i++) begin
        set_temps((i == 0) ? first[p] : 5'd20, 5'd20, 5'd20, 5'd20);
        sbq.push_back('{heat: {3'b000, on[i] & (p == 0)}, cool: {3'b000, on[i] & (p == 1)}});
        @(posedge clk);
        @(negedge clk);
        e  = sbq.pop_front();
        en = 3'($countones(e.heat | e.cool));
        checks++;
        if ({heat3, cool3, cnt3} !== {e.heat, e.cool, en}) begin
          errors++;
          $display("FAIL dwell phase %0d step %0d: got h=%b c=%b n=%0d expected h=%b c=%b n=%0d",
                   p, i, heat3, cool3, cnt3, e.heat, e.cool, en);
        end
      end
    end
  endtask

  task automatic test_override();
    logic [1:0] md   [6] = '{2'b11, 2'b01, 2'b01, 2'b11, 2'b11, 2'b11};
    logic [3:0] ena  [6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE};
    logic [4:0] tmp  [6] = '{5'd24, 5'd24, 5'd24, 5'd16, 5'd16, 5'd16};
    logic [1:0] hc   [6] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
    exp_t       e;
    logic [2:0] en;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || i == 3) settle();
      mode    = md[i];
      zone_en = ena[i];
      set_temps(tmp[i], 5'd20, 5'd20, 5'd20);
      sbq.push_back('{heat: {3'b000, hc[i][1]}, cool: {3'b000, hc[i][0]}});
      @(posedge clk);
      @(negedge clk);
      e  = sbq.pop_front();
      en = 3'($countones(e.heat | e.cool));
      checks++;
      if ({heat3, cool3, cnt3} !== {e.heat, e.cool, en}) begin
        errors++;
        $display("FAIL override step %0d: got h=%b c=%b n=%0d expected h=%b c=%b n=%0d",
                 i, heat3, cool3, cnt3, e.heat, e.cool, en);
      end
    end
    zone_en = 4'hF;
  endtask

  task automatic test_multizone();
    exp_t       e;
    logic [2:0] en;
    settle();
    for (int i = 0; i < 2; i++) begin
      set_temps(5'd16, 5'd24, 5'd20, 5'd18);
      sbq.push_back('{heat: 4'b1001, cool: 4'b0010});
      @(posedge clk);
      @(negedge clk);
      e  = sbq.pop_front();
      en = 3'($countones(e.heat | e.cool));
      checks++;
      if ({heat0, cool0, cnt0} !== {e.heat, e.cool, en}) begin
        errors++;
        $display("FAIL multizone step %0d: got h=%b c=%b n=%0d expected h=%b c=%b n=%0d",
                 i, heat0, cool0, cnt0, e.heat, e.cool, en);
      end
    end
  endtask

  // Threshold saturation at both ends of the range and band 0 treated as 1.
  task automatic test_band();
    logic [4:0]  sp  [4] = '{5'd1, 5'd30, 5'd30, 5'd20};
    logic [4:0]  bd  [4] = '{5'd3, 5'd3, 5'd3, 5'd0};
    logic [19:0] tv  [4] = '{{5'd3, 5'd2, 5'd1, 5'd0},
                             {5'd30, 5'd26, 5'd31, 5'd31},
                             {5'd30, 5'd26, 5'd31, 5'd31},
                             {5'd20, 5'd20, 5'd21, 5'd19}};
    exp_t        ex  [4] = '{'{heat: 4'b0001, cool: 4'b0000},
                             '{heat: 4'b0100, cool: 4'b0000},
                             '{heat: 4'b0100, cool: 4'b0000},
                             '{heat: 4'b0001, cool: 4'b0010}};
    exp_t        e;
    logic [2:0]  en;
    settle();
    for (int i = 0; i < 4; i++) begin
      setpoint    = sp[i];
      band        = bd[i];
      temperature = tv[i];
      sbq.push_back(ex[i]);
      @(posedge clk);
      @(negedge clk);
      e  = sbq.pop_front();
      en = 3'($countones(e.heat | e.cool));
      checks++;
      if ({heat0, cool0, cnt0} !== {e.heat, e.cool, en}) begin
        errors++;
        $display("FAIL band step %0d: got h=%b c=%b n=%0d expected h=%b c=%b n=%0d",
                 i, heat0, cool0, cnt0, e.heat, e.cool, en);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t       e;
    logic [2:0] en;
    settle();
    set_temps(5'd16, 5'd24, 5'd20, 5'd20);
    sbq.push_back('{heat: 4'b0001, cool: 4'b0010});
    @(posedge clk);
    @(negedge clk);
    e  = sbq.pop_front();
    en = 3'($countones(e.heat | e.cool));
    checks++;
    if ({heat0, cool0, cnt0} !== {e.heat, e.cool, en}) begin
      errors++;
      $display("FAIL areset pre: got h=%b c=%b n=%0d expected h=%b c=%b n=%0d",
               heat0, cool0, cnt0, e.heat, e.cool, en);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({heat0, cool0, cnt0} !== 11'd0) begin
      errors++;
      $display("FAIL areset dut0: got h=%b c=%b n=%0d expected all 0", heat0, cool0, cnt0);
    end
    checks++;
    if ({heat3, cool3, cnt3} !== 11'd0) begin
      errors++;
      $display("FAIL areset dut3: got h=%b c=%b n=%0d expected all 0", heat3, cool3, cnt3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sbq.push_back('{heat: 4'b0001, cool: 4'b0010});
    @(posedge clk);
    @(negedge clk);
    e  = sbq.pop_front();
    en = 3'($countones(e.heat | e.cool));
    checks++;
    if ({heat0, cool0, cnt0} !== {e.heat, e.cool, en}) begin
      errors++;
      $display("FAIL areset release dut0: got h=%b c=%b n=%0d expected h=%b c=%b n=%0d",
               heat0, cool0, cnt0, e.heat, e.cool, en);
    end
    checks++;
    if ({heat3, cool3, cnt3} !== {e.heat, e.cool, en}) begin
      errors++;
      $display("FAIL areset release dut3: got h=%b c=%b n=%0d expected h=%b c=%b n=%0d",
               heat3, cool3, cnt3, e.heat, e.cool, en);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    test_reset();
    test_sequence();
    test_dwell();
    test_override();
    test_multizone();
    test_band();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/air_zone_ctrl.md
# air_zone_ctrl

Multi-zone air-conditioning controller: a parametrised successor to the single-zone `air` hysteresis controller. It runs one IDLE/HEAT/COOL state machine per zone against a shared runtime setpoint and hysteresis band. It adds per-zone enables, a global operating mode, a minimum-dwell (compressor protection) counter per zone, and an active-zone count. It sits between the zone temperature sensors and the heater/chiller drivers.

## Interface
- `WIDTH`, 5: temperature/setpoint/band width, unsigned.
- `ZONES`, 4: number of independent zones.
- `DWELL`, 0: extra cycles a state must be held after entry; 0 gives one-cycle minimum.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; one clock, asynchronous and active-low.
- `mode`  in  2  00 off, 01 heat-only, 10 cool-only, 11 auto.
- `zone_en`  in  ZONES  per-zone enable, bit z = zone z.
- `setpoint`  in  WIDTH  target temperature.
- `band`  in  WIDTH  hysteresis half-width; value 0 treated as 1.
- `temperature`  in  ZONES*WIDTH  zone z at bits [z*WIDTH +: WIDTH].
- `heating`  out  ZONES  zone z in HEAT.
- `cooling`  out  ZONES  zone z in COOL.
- `active_cnt`  out  $clog2(ZONES+1)  number of zones in HEAT or COOL.

## Operation
- Effective band `b = max(band,1)`. All comparisons are unsigned in WIDTH+1 bits.
- heat_on: `temp <= sp - b`. If `b > sp`, the threshold saturates to 0, so heat_on only at temp 0.
- heat_off: `temp >= sp`.
- cool_on: `temp >= sp + b`. If `sp + b > 2^WIDTH - 1`, cool_on is never true.
- cool_off: `temp <= sp`.
- heat_on and cool_on are mutually exclusive by construction.
- Per-zone states: IDLE, HEAT, COOL. Encoding is free. `heating`/`cooling` decode directly from the state register; {1,1} never occurs.
- Transitions, evaluated only when the zone's dwell counter is 0:
  - IDLE→HEAT on heat_on, if mode is 01 or 11.
  - IDLE→COOL on cool_on, if mode is 10 or 11.
  - HEAT→IDLE on heat_off.
  - COOL→IDLE on cool_off.
  - No direct HEAT↔COOL transition.
- Forced IDLE, which ignores the dwell counter and clears it to 0:
  - `zone_en[z]`=0.
  - mode 00.
  - HEAT while mode is 10.
  - COOL while mode is 01.
- Dwell counter, width $clog2(DWELL+1), DWELL=0 → constant 0:
  - Loads DWELL on every non-forced state change.
  - Otherwise decrements when nonzero.
  - Consequence: a state is held ≥ DWELL+1 cycles, except on forced IDLE.
- `active_cnt` is a registered popcount of the next-state HEAT|COOL, so it is coherent with `heating|cooling` on the same cycle.
- With WIDTH=5, setpoint=20, band=2, DWELL=0, mode=11 and all zones enabled, each zone behaves bit-identically to `air`: heat at ≤18 until ≥20, cool at ≥22 until ≤20.

## Timing
- All inputs are sampled at the rising edge of `clk`. Outputs are registered and change only after that edge, i.e. one cycle of latency from temperature to output.
- `setpoint`, `band` and `mode` may change on any cycle. The new values take effect at the next edge for every zone simultaneously.
- `rst_n` low → immediately, without waiting for an edge: all zones IDLE, counters 0, `heating`=0, `cooling`=0, `active_cnt`=0. This applies mid-operation as well.
- The first transition is possible at the first edge after `rst_n` is released.
- Zones are fully independent: no arbitration and no cross-zone limit.

## Test plan
- Defaults, zone 0: temperature per cycle 20,19,21,16,20,24,20 → {heating,cooling} one cycle later 00,00,00,10,00,01,00.
- DWELL=3: zone 0 at 16 for 1 cycle, then 20 → `heating[0]`=1 for exactly 4 cycles, then 0. Repeat with 24→20 for cooling.
- Mode/enable override, DWELL=3: zone in COOL, mode set to 01 on the next cycle → `cooling` drops at the following edge despite dwell; temperature 24 then keeps the zone IDLE. Drop `zone_en[0]` during HEAT → `heating[0]`=0 next edge.
- Multi-zone, ZONES=4, setpoint 20, band 2: temperatures z0..z3 = 16,24,20,18 → `heating`=4'b1001, `cooling`=4'b0010, `active_cnt`=3.
- Saturation/band: setpoint 1, band 3 → temperature 0 heats, 1 does not. Setpoint 30, band 3 → temperature 31 never cools. Band 0 with setpoint 20 → 19 heats, 21 cools, 20 idles.
- Async reset: pull `rst_n` low mid-cycle while zones heat or cool → all outputs 0 before the next edge. After release with temperature 16, `heating` asserts at the first edge.
